// File: rtl/devbridge_pkg.sv
// Shared types and constants for the memory-mapped device bridge.
package devbridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int STAT_OVF     = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_BUSY    = 3;
  localparam int STAT_TMO     = 4;
  localparam int STAT_CNT_LSB = 8;
  localparam int STAT_CNT_MSB = 15;

  // Byte offset of the status register from the window base.
  function automatic int status_offset(input int num_ch);
    return 4 * num_ch;
  endfunction

  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/mmio_device_bridge_if.sv
// CPU, data-memory and transmitter signals of the device bridge; master = environment, slave = bridge.
interface mmio_device_bridge_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int CH_W   = 2
);

  logic              writeIn;
  logic              readIn;
  logic [ADDR_W-1:0] addressIn;
  logic [DATA_W-1:0] dataIn;
  logic [DATA_W-1:0] memOutIn;
  logic              writeOut;
  logic              readOut;
  logic [DATA_W-1:0] memOutOut;
  logic [DATA_W-1:0] tx_data;
  logic [CH_W-1:0]   tx_channel;
  logic              start;
  logic              finish;

  modport master (
    output writeIn, readIn, addressIn, dataIn, memOutIn, finish,
    input  writeOut, readOut, memOutOut, tx_data, tx_channel, start
  );

  modport slave (
    input  writeIn, readIn, addressIn, dataIn, memOutIn, finish,
    output writeOut, readOut, memOutOut, tx_data, tx_channel, start
  );

endinterface

// File: rtl/devbridge_fifo.sv
// Synchronous FIFO with wrap-around pointers and an occupancy count.
// Latency: a pushed entry appears on rdata the cycle after the push.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module devbridge_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mmio_device_bridge.sv
// Device bridge: memory pass-through plus queued channel stores drained via start/finish (optional DEVBRIDGE_TIMEOUT_EN).
// Latency: pass-through combinational; store to an idle, empty bridge raises start two cycles later.
// Backpressure: none toward the CPU; stores to a full queue are dropped and flagged sticky overflow.
module mmio_device_bridge
  import devbridge_pkg::*;
#(
  parameter int              DATA_W         = 32,
  parameter int              ADDR_W         = 32,
  parameter int              NUM_CH         = 4,
  parameter int              DEPTH          = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h0000_0400,
  parameter int              TIMEOUT_CYCLES = 100000
) (
  input logic                 clock,
  input logic                 reset,
  mmio_device_bridge_if.slave bus
);

  localparam int CH_W   = ch_width(NUM_CH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int WORD_W = ADDR_W - 2;
  localparam logic [WORD_W-1:0] BASE_WORD   = BASE_ADDR[ADDR_W-1:2];
  localparam logic [ADDR_W-1:0] STATUS_ADDR = BASE_ADDR + ADDR_W'(status_offset(NUM_CH));
  localparam logic [WORD_W-1:0] STATUS_WORD = STATUS_ADDR[ADDR_W-1:2];
  localparam logic [WORD_W-1:0] NUM_CH_WORD = WORD_W'(NUM_CH);

  state_t state_q, state_d;

  logic [WORD_W-1:0]      rel_word;
  logic                   ch_hit;
  logic                   status_hit;
  logic                   dev_hit;
  logic [CH_W-1:0]        ch_idx;
  logic                   push_req;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CNT_W-1:0]       fifo_count;
  logic [DATA_W+CH_W-1:0] fifo_head;
  logic [DATA_W-1:0]      tx_data_q;
  logic [CH_W-1:0]        tx_ch_q;
  logic                   ovf_q;
  logic                   ovf_set;
  logic                   flag_clr;
  logic                   tmo_hit;
  logic                   tmo_flag;
  logic [DATA_W-1:0]      status_word;
  logic                   unused_addr_lsb;

  // Word-granular decode: distance from the window base selects channel or status.
  assign rel_word        = bus.addressIn[ADDR_W-1:2] - BASE_WORD;
  assign ch_hit          = (rel_word < NUM_CH_WORD);
  assign status_hit      = (bus.addressIn[ADDR_W-1:2] == STATUS_WORD);
  assign dev_hit         = ch_hit | status_hit;
  assign ch_idx          = rel_word[CH_W-1:0];
  assign unused_addr_lsb = ^bus.addressIn[1:0];

  assign bus.writeOut  = bus.writeIn & ~dev_hit;
  assign bus.readOut   = bus.readIn & ~dev_hit;
  assign bus.memOutOut = (bus.readIn & status_hit) ? status_word : bus.memOutIn;

  assign push_req = bus.writeIn & ch_hit;
  assign ovf_set  = push_req & fifo_full & ~pop;
  assign flag_clr = bus.writeIn & status_hit & bus.dataIn[0];

  devbridge_fifo #(
    .WIDTH (DATA_W + CH_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_req),
    .wdata ({ch_idx, bus.dataIn}),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus.finish || tmo_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      tx_data_q <= '0;
      tx_ch_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        tx_data_q <= fifo_head[DATA_W-1:0];
        tx_ch_q   <= fifo_head[DATA_W +: CH_W];
      end
      if (ovf_set)       ovf_q <= 1'b1;
      else if (flag_clr) ovf_q <= 1'b0;
    end
  end

`ifdef DEVBRIDGE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_q;

  // Counter idles at zero outside WAIT, so it starts fresh on every entry.
  always_ff @(posedge clock) begin
    if (!reset || state_q != WAIT) tmo_cnt <= '0;
    else                           tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state_q == WAIT) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (!reset)                     tmo_q <= 1'b0;
    else if (tmo_hit && !bus.finish) tmo_q <= 1'b1;
    else if (flag_clr)              tmo_q <= 1'b0;
  end

  assign tmo_flag = tmo_q;
`else
  logic unused_tmo_cfg;

  assign tmo_hit        = 1'b0;
  assign tmo_flag       = 1'b0;
  assign unused_tmo_cfg = TIMEOUT_CYCLES[0];
`endif

  always_comb begin
    status_word                             = '0;
    status_word[STAT_OVF]                   = ovf_q;
    status_word[STAT_FULL]                  = fifo_full;
    status_word[STAT_EMPTY]                 = fifo_empty;
    status_word[STAT_BUSY]                  = (state_q != IDLE);
    status_word[STAT_TMO]                   = tmo_flag;
    status_word[STAT_CNT_MSB:STAT_CNT_LSB]  = 8'(fifo_count);
  end

  assign bus.start      = (state_q == ISSUE);
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_channel = tx_ch_q;

endmodule

// File: tb/tb_mmio_device_bridge.sv
// Directed bench for mmio_device_bridge with NUM_CH=4, DEPTH=8, BASE=0x400 (STATUS at 0x410).
module tb_mmio_device_bridge;
  import devbridge_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = 2;
  localparam logic [31:0] STATUS = 32'h0000_0410;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] exp_d  [8];
  logic [1:0]  exp_ch [8];
  logic [31:0] sv;

  mmio_device_bridge_if #(.DATA_W(DW), .ADDR_W(AW), .CH_W(CW)) bus ();

  mmio_device_bridge #(
    .DATA_W         (DW),
    .ADDR_W         (AW),
    .NUM_CH         (4),
    .DEPTH          (8),
    .BASE_ADDR      (32'h0000_0400),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic [31:0] exp);
    bus.readIn    = 1'b1;
    bus.addressIn = STATUS;
    #2;
    sv = bus.memOutOut;
    bus.readIn = 1'b0;
    chk(tag, sv, exp);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    bus.writeIn   = 1'b1;
    bus.addressIn = addr;
    bus.dataIn    = data;
    cyc();
    bus.writeIn = 1'b0;
  endtask

  // From ISSUE: move to WAIT, finish in the first WAIT cycle, pop next word in IDLE.
  task automatic finish_word();
    cyc();
    bus.finish = 1'b1;
    cyc();
    bus.finish = 1'b0;
    cyc();
  endtask

  initial begin
    bus.writeIn   = 1'b0;
    bus.readIn    = 1'b0;
    bus.addressIn = '0;
    bus.dataIn    = '0;
    bus.memOutIn  = '0;
    bus.finish    = 1'b0;
    for (int i = 0; i < 7; i++) begin
      exp_d[i]  = 32'h0000_0102 + i;
      exp_ch[i] = 2'd0;
    end
    exp_d[7]  = 32'h0000_0AAA;
    exp_ch[7] = 2'd3;

    // Reset state
    cyc();
    cyc();
    chk("rst_start", bus.start, 1'b0);
    chk("rst_tx_data", bus.tx_data, 32'h0);
    chk("rst_tx_ch", bus.tx_channel, 2'd0);
    chk_status("rst_status", 32'h0000_0004);
    reset = 1'b1;
    cyc();

    // Single store to CH2
    bus.writeIn   = 1'b1;
    bus.addressIn = 32'h0000_0408;
    bus.dataIn    = 32'hDEAD_BEEF;
    #2;
    chk("ch2_writeOut", bus.writeOut, 1'b0);
    cyc();
    bus.writeIn = 1'b0;
    chk("ch2_no_start_t1", bus.start, 1'b0);
    chk_status("ch2_status_t1", 32'h0000_0100);
    cyc();
    chk("ch2_start", bus.start, 1'b1);
    chk("ch2_tx_data", bus.tx_data, 32'hDEAD_BEEF);
    chk("ch2_tx_ch", bus.tx_channel, 2'd2);
    chk_status("ch2_status_issue", 32'h0000_000C);
    cyc();
    chk("ch2_start_once", bus.start, 1'b0);
    repeat (4) cyc();
    chk_status("ch2_wait_busy", 32'h0000_000C);
    chk("ch2_hold_data", bus.tx_data, 32'hDEAD_BEEF);
    bus.finish = 1'b1;
    cyc();
    bus.finish = 1'b0;
    chk_status("ch2_done_idle", 32'h0000_0004);
    chk("ch2_no_restart", bus.start, 1'b0);

    // Pass-through and decode boundaries
    bus.writeIn   = 1'b1;
    bus.addressIn = 32'h0000_0100;
    bus.dataIn    = 32'h5555_AAAA;
    #2;
    chk("pt_writeOut", bus.writeOut, 1'b1);
    chk("pt_readOut_idle", bus.readOut, 1'b0);
    bus.writeIn  = 1'b0;
    bus.readIn   = 1'b1;
    bus.memOutIn = 32'h1234_5678;
    #1;
    chk("pt_readOut", bus.readOut, 1'b1);
    chk("pt_memOut", bus.memOutOut, 32'h1234_5678);
    bus.addressIn = 32'h0000_0404;
    #1;
    chk("ch1_read_blocked", bus.readOut, 1'b0);
    chk("ch1_read_mem", bus.memOutOut, 32'h1234_5678);
    bus.addressIn = 32'h0000_0413;
    #1;
    chk("status_lsb_ignored", bus.memOutOut, 32'h0000_0004);
    bus.addressIn = 32'h0000_0414;
    #1;
    chk("past_status_readOut", bus.readOut, 1'b1);
    bus.addressIn = 32'h0000_03FC;
    #1;
    chk("below_base_readOut", bus.readOut, 1'b1);
    bus.readIn = 1'b0;
    cyc();
    chk_status("pt_count_zero", 32'h0000_0004);

    // Fill: first word goes out, eight more fill the FIFO, one more overflows
    for (int i = 0; i < 9; i++) store(32'h0000_0400, 32'h0000_0100 + i);
    chk_status("fill_full", 32'h0000_080A);
    chk("fill_tx_data", bus.tx_data, 32'h0000_0100);
    store(32'h0000_0400, 32'h0000_0109);
    chk_status("fill_overflow", 32'h0000_080B);

    // Overflow clearing
    store(STATUS, 32'h0000_0000);
    chk_status("clr_bit0_zero", 32'h0000_080B);
    bus.writeIn   = 1'b1;
    bus.addressIn = STATUS;
    bus.dataIn    = 32'h0000_0001;
    #2;
    chk("clr_same_cycle", bus.memOutOut, bus.memOutIn);
    cyc();
    bus.writeIn = 1'b0;
    chk_status("clr_done", 32'h0000_080A);
    store(32'h0000_0408, 32'h0000_0999);
    chk_status("reoverflow", 32'h0000_080B);
    store(STATUS, 32'h0000_0001);
    chk_status("clr_again", 32'h0000_080A);

    // Push on full while the FSM pops the head
    bus.finish = 1'b1;
    cyc();
    bus.finish = 1'b0;
    chk_status("full_idle", 32'h0000_0802);
    store(32'h0000_040C, 32'h0000_0AAA);
    chk("swap_start", bus.start, 1'b1);
    chk("swap_tx_data", bus.tx_data, 32'h0000_0101);
    chk_status("swap_status", 32'h0000_080A);
    for (int j = 0; j < 8; j++) begin
      finish_word();
      chk($sformatf("drain%0d_start", j), bus.start, 1'b1);
      chk($sformatf("drain%0d_data", j), bus.tx_data, exp_d[j]);
      chk($sformatf("drain%0d_ch", j), bus.tx_channel, exp_ch[j]);
    end
    cyc();
    bus.finish = 1'b1;
    cyc();
    bus.finish = 1'b0;
    chk_status("drain_empty", 32'h0000_0004);

    // Reset in WAIT with three entries queued
    for (int i = 0; i < 4; i++) store(32'h0000_0404, 32'h0000_0201 + i);
    chk_status("prerst_status", 32'h0000_0308);
    chk("prerst_tx_ch", bus.tx_channel, 2'd1);
    reset = 1'b0;
    cyc();
    chk_status("midrst_status", 32'h0000_0004);
    chk("midrst_start", bus.start, 1'b0);
    chk("midrst_tx_data", bus.tx_data, 32'h0);
    chk("midrst_tx_ch", bus.tx_channel, 2'd0);
    reset = 1'b1;
    cyc();
    bus.finish = 1'b1;
    cyc();
    bus.finish = 1'b0;
    chk("stray_finish_start", bus.start, 1'b0);
    cyc();
    chk("stray_finish_start2", bus.start, 1'b0);
    chk_status("stray_finish_status", 32'h0000_0004);

`ifdef DEVBRIDGE_TIMEOUT_EN
    // Ten WAIT cycles without finish abandon the word
    store(32'h0000_0400, 32'h0000_0301);
    cyc();
    cyc();
    repeat (9) cyc();
    chk_status("tmo_still_wait", 32'h0000_000C);
    cyc();
    chk_status("tmo_fired", 32'h0000_0014);
    store(STATUS, 32'h0000_0001);
    chk_status("tmo_cleared", 32'h0000_0004);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
